rt_timer_scanner: RTL
=====================

Name: rt_timer_scanner

Overview:
- Per-flow retransmit timer block; sits directly upstream of the round-robin scheduler engine as its TX-side update source.
- TX arms or re-arms a flow's timer when it sends data; RX disarms it when all data is acked.
- A background scanner walks all flows. For each expired armed flow it emits one scheduler update command that sets the flow's rt pending flag.

Parameters:
- FLOWID_W, 8, flow id width; table depth is 2^FLOWID_W.
- TIMER_W, 16, width of tick counter, deadlines and timeouts.
- TICK_DIV, 1000, clock cycles per timer tick (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- new_flow_val  in  1  new flow; clears that flow's entry; no backpressure.
- new_flow_flowid  in  FLOWID_W  flow being created.
- arm_val  in  1  arm/re-arm request.
- arm_flowid  in  FLOWID_W  flow to arm.
- arm_timeout  in  TIMER_W  timeout in ticks.
- arm_rdy  out  1  arm accepted when val&rdy.
- disarm_val  in  1  disarm request.
- disarm_flowid  in  FLOWID_W  flow to disarm.
- disarm_rdy  out  1  disarm accepted when val&rdy.
- rt_sched_update_val  out  1  expiry command valid.
- rt_sched_update_cmd  out  SCHED_CMD_STRUCT_W  sched_cmd_struct.
- sched_rt_update_rdy  in  1  scheduler accepts command.

Behaviour:
- Reset (rst_n low, async):
  - all armed bits = 0; tick_now = 0; tick_div_cnt = 0; scan_ptr = 0; state = SCAN.
  - rt_sched_update_val = 0.
  - Deadline array is not reset.
- Tick counter:
  - tick_div_cnt counts 0..TICK_DIV-1.
  - On the wrap cycle, tick_now increments, modulo 2^TIMER_W.
- Per-flow state: armed bit (flop vector) and deadline[TIMER_W] (flop array, single write port).
- Write-port priority: new_flow > disarm > arm.
  - disarm_rdy = ~new_flow_val.
  - arm_rdy = ~new_flow_val & ~disarm_val.
  - Both are combinational; an accepted request takes effect at the next edge.
- new_flow: armed[id] <= 0; deadline[id] <= 0.
- disarm: armed[id] <= 0.
- arm:
  - armed[id] <= 1; deadline[id] <= tick_now + arm_timeout (modulo 2^TIMER_W).
  - Re-arming an armed flow overwrites its deadline.
- Expiry test (wrap-safe): armed[id] & ~msb(tick_now - deadline[id]), computed in TIMER_W bits.
  - Legal arm_timeout < 2^(TIMER_W-1).
  - arm_timeout = 0 expires when the scanner next reaches the flow.
- FSM SCAN:
  - Each cycle, read entry scan_ptr combinationally.
  - Not expired: scan_ptr <= scan_ptr+1, wrapping 2^FLOWID_W-1 -> 0.
  - Expired, and no accepted new_flow/disarm/arm to the same flowid this cycle:
    - armed[scan_ptr] <= 0;
    - latch cmd;
    - go ISSUE.
  - Expired but a same-cycle accepted update hits that flowid: the update wins, no command is issued, scan_ptr advances.
- FSM ISSUE:
  - rt_sched_update_val = 1, with cmd held stable.
  - On sched_rt_update_rdy: scan_ptr <= scan_ptr+1; go SCAN.
  - Arm/disarm remain serviced during ISSUE.
  - A re-arm of the issued flow does not retract the command.
- Command fields:
  - flowid = latched flow.
  - rt_pend_set_clear = SET encoding.
  - ack_pend_set_clear and data_pend_set_clear = NOP encoding.
  - All encodings from tcp_misc_pkg.
- Latency:
  - Minimum one cycle from SCAN detection to val high.
  - A full sweep with no expiries takes 2^FLOWID_W cycles.
  - Worst-case detection delay is one sweep plus one cycle per pending command.
- At most one command outstanding; commands stay in scan order.
- A flow expires at most once per arm.
- Reset mid-ISSUE: val drops immediately; the command is lost; the flow stays disarmed.

Test Plan:
- Reset, then TICK_DIV=4:
  - arm flow 5 with timeout 3 at tick 0;
  - rdy tied 1;
  - -> exactly one command {flowid=5, rt=SET, ack=NOP, data=NOP} once tick_now >= 3, and none before;
  - armed[5]=0 afterward.
- Arm flow 7 with timeout 10, then disarm flow 7 at tick 5 -> no command for flow 7 within 3 sweeps.
- Wrap:
  - arm at tick_now=0xFFFE with timeout 4 (deadline 0x0002);
  - -> no command at ticks 0xFFFF and 0x0001; command issued at tick 0x0002.
- Backpressure:
  - flows 1, 2, 3 expired, rdy held 0 for 50 cycles;
  - -> val high, cmd.flowid=1 stable throughout;
  - after rdy: flows 1, 2, 3 are issued in that order, one handshake each.
- Collision:
  - same cycle: new_flow_val on id 9, disarm_val on id 4, arm_val on id 6;
  - -> disarm_rdy=0, arm_rdy=0; flow 9 cleared.
  - Next cycle: disarm accepted, arm_rdy=0.
  - Cycle after: arm accepted.
- Scanner reaching an expired flow 12 in the same cycle as an accepted arm of flow 12 with timeout 20 -> no command; flow 12 re-armed with the new deadline.

Source files
------------

// File: rtl/rt_timer_scanner.sv
// Per-flow retransmit timer table with a background expiry scanner.
// TX arms/re-arms flows, RX disarms them, and the scanner turns each expired
// armed flow into one "set rt pending" command for the round-robin scheduler.

package tcp_misc_pkg;

  localparam int FLOWID_W = 8;

  typedef logic [FLOWID_W-1:0] flowid_t;

  // Set/clear/no-op encoding shared by all scheduler pending flags.
  typedef enum logic [1:0] {
    PEND_NOP   = 2'd0,
    PEND_SET   = 2'd1,
    PEND_CLEAR = 2'd2
  } pend_set_clear_e;

  typedef struct packed {
    flowid_t         flowid;
    pend_set_clear_e rt_pend_set_clear;
    pend_set_clear_e ack_pend_set_clear;
    pend_set_clear_e data_pend_set_clear;
  } sched_cmd_struct;

  localparam int SCHED_CMD_STRUCT_W = $bits(sched_cmd_struct);

endpackage

module rt_timer_scanner #(
  parameter int FLOWID_W = tcp_misc_pkg::FLOWID_W,
  parameter int TIMER_W  = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      new_flow_val,
  input  logic [FLOWID_W-1:0]                       new_flow_flowid,
  input  logic                                      arm_val,
  input  logic [FLOWID_W-1:0]                       arm_flowid,
  input  logic [TIMER_W-1:0]                        arm_timeout,
  output logic                                      arm_rdy,
  input  logic                                      disarm_val,
  input  logic [FLOWID_W-1:0]                       disarm_flowid,
  output logic                                      disarm_rdy,
  output logic                                      rt_sched_update_val,
  output logic [tcp_misc_pkg::SCHED_CMD_STRUCT_W-1:0] rt_sched_update_cmd,
  input  logic                                      sched_rt_update_rdy
);

  localparam int DEPTH = 1 << FLOWID_W;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    ST_SCAN,
    ST_ISSUE
  } state_e;

  state_e              state;
  state_e              state_nxt;

  logic [DIV_W-1:0]    tick_div_cnt;
  logic [TIMER_W-1:0]  tick_now;

  logic [DEPTH-1:0]    armed;
  logic [TIMER_W-1:0]  deadline [DEPTH];

  logic [FLOWID_W-1:0] scan_ptr;
  logic [TIMER_W-1:0]  scan_delta;
  logic                scan_expired;
  logic                scan_hit;
  logic                scan_adv;
  logic                scan_clear;

  logic                wr_en;
  logic [FLOWID_W-1:0] wr_id;
  logic                wr_armed;
  logic                wr_dl_en;
  logic [TIMER_W-1:0]  wr_dl;

  tcp_misc_pkg::sched_cmd_struct cmd;

  // Free-running tick: tick_now advances once every TICK_DIV clocks.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_div_cnt <= '0;
      tick_now     <= '0;
    end else if (tick_div_cnt == DIV_W'(TICK_DIV - 1)) begin
      tick_div_cnt <= '0;
      tick_now     <= tick_now + 1'b1;
    end else begin
      tick_div_cnt <= tick_div_cnt + 1'b1;
    end
  end

  // Ready handshakes: new_flow always wins, then disarm, then arm.
  assign disarm_rdy = ~new_flow_val;
  assign arm_rdy    = ~new_flow_val & ~disarm_val;

  // Select the single table write for this cycle by priority.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    wr_en    = 1'b0;
    wr_id    = '0;
    wr_armed = 1'b0;
    wr_dl_en = 1'b0;
    wr_dl    = '0;
    if (new_flow_val) begin
      wr_en    = 1'b1;
      wr_id    = new_flow_flowid;
      wr_dl_en = 1'b1;
    end else if (disarm_val) begin
      wr_en    = 1'b1;
      wr_id    = disarm_flowid;
    end else if (arm_val) begin
      wr_en    = 1'b1;
      wr_id    = arm_flowid;
      wr_armed = 1'b1;
      wr_dl_en = 1'b1;
      wr_dl    = tick_now + arm_timeout;
    end
  end

  // Armed bits: request writes, plus the scanner clearing a flow it issues.
  // The two never target the same flow because a hit suppresses the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= '0;
    end else begin
      if (wr_en) armed[wr_id] <= wr_armed;
      if (scan_clear) armed[scan_ptr] <= 1'b0;
    end
  end

  // Deadline storage; only meaningful while the matching armed bit is set.
  // NOTE: this array has no reset: armed gates every read, and a resettable
  // table would cost a reset tree across every entry for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_dl_en) deadline[wr_id] <= wr_dl;
  end

  // Wrap-safe expiry: the flow is due once tick_now - deadline is non-negative
  // in TIMER_W-bit two's complement.
  assign scan_delta   = tick_now - deadline[scan_ptr];
  assign scan_expired = armed[scan_ptr] & ~scan_delta[TIMER_W-1];
  assign scan_hit     = wr_en && (wr_id == scan_ptr);

  // Scanner FSM next-state: advance, or capture an expired flow for issue.
  always_comb begin
    state_nxt  = state;
    scan_adv   = 1'b0;
    scan_clear = 1'b0;
    case (state)
      ST_SCAN: begin
        if (scan_expired && !scan_hit) begin
          scan_clear = 1'b1;
          state_nxt  = ST_ISSUE;
        end else begin
          scan_adv = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (sched_rt_update_rdy) begin
          scan_adv  = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  // FSM state and scan pointer. The pointer is frozen during ISSUE, so it
  // doubles as the latched flowid of the outstanding command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SCAN;
      scan_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (scan_adv) scan_ptr <= scan_ptr + 1'b1;
    end
  end

  // Command: only rt pending is touched; ack and data pending are left alone.
  always_comb begin
    cmd                     = '0;
    cmd.flowid              = tcp_misc_pkg::flowid_t'(scan_ptr);
    cmd.rt_pend_set_clear   = tcp_misc_pkg::PEND_SET;
    cmd.ack_pend_set_clear  = tcp_misc_pkg::PEND_NOP;
    cmd.data_pend_set_clear = tcp_misc_pkg::PEND_NOP;
  end

  assign rt_sched_update_val = (state == ST_ISSUE);
  assign rt_sched_update_cmd = cmd;

endmodule
